// File: rtl/lsu_mem_ctrl.sv
// rtl/lsu_mem_ctrl.sv - load/store unit bridging the memory stage to a req/ack data bus with timeout
// Optional misaligned-access trapping is enabled by defining MISALIGN_TRAP_EN.
module lsu_mem_ctrl #(
    parameter int TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        is_load,
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] st_data,
    output logic        stall,
    output logic [31:0] d_rdata,
    output logic        rd_valid,
    output logic        err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wmask,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;
    localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);

    logic [1:0]  state;
    logic [7:0]  timer;
    logic [2:0]  op_funct3;
    logic [1:0]  op_off;
    logic        op_load;
    logic        accept;
    logic        illegal;
    logic        misaligned;
    logic        timeout_hit;
    logic [3:0]  st_mask;
    logic [31:0] st_wdata;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_data;

    assign accept      = (state == IDLE) && req_valid && (is_load || is_store);
    assign stall       = accept || (state == BUSY);
    assign timeout_hit = (timer == TIMER_LAST);

`ifdef MISALIGN_TRAP_EN
    assign misaligned = ((funct3[1:0] == 2'b01) && addr[0]) ||
                        ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
`else
    assign misaligned = 1'b0;
`endif

    assign illegal = (is_load && is_store) ||
                     (is_load && ((funct3 == 3'b011) || (funct3[2:1] == 2'b11))) ||
                     (is_store && (funct3[2] || (funct3[1:0] == 2'b11))) ||
                     misaligned;

    always_comb begin
        st_mask  = 4'b1111;
        st_wdata = st_data;
        case (funct3[1:0])
            2'b00: begin
                st_mask  = 4'b0001 << addr[1:0];
                st_wdata = {4{st_data[7:0]}};
            end
            2'b01: begin
                st_mask  = 4'b0011 << {addr[1], 1'b0};
                st_wdata = {2{st_data[15:0]}};
            end
            default: begin
                st_mask  = 4'b1111;
                st_wdata = st_data;
            end
        endcase
    end

    // Lane selection uses the offset latched at accept, not the live address.
    always_comb begin
        ld_byte = mem_rdata[7:0];
        case (op_off)
            2'd1:    ld_byte = mem_rdata[15:8];
            2'd2:    ld_byte = mem_rdata[23:16];
            2'd3:    ld_byte = mem_rdata[31:24];
            default: ld_byte = mem_rdata[7:0];
        endcase
        ld_half = op_off[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        ld_data = 32'd0;
        case (op_funct3)
            3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
            3'b010:  ld_data = mem_rdata;
            3'b100:  ld_data = {24'd0, ld_byte};
            3'b101:  ld_data = {16'd0, ld_half};
            default: ld_data = 32'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            timer     <= 8'd0;
            op_funct3 <= 3'd0;
            op_off    <= 2'd0;
            op_load   <= 1'b0;
            d_rdata   <= 32'd0;
            rd_valid  <= 1'b0;
            err       <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 32'd0;
            mem_wdata <= 32'd0;
            mem_wmask <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    rd_valid <= 1'b0;
                    err      <= 1'b0;
                    if (accept) begin
                        op_funct3 <= funct3;
                        op_off    <= addr[1:0];
                        op_load   <= is_load;
                        if (illegal) begin
                            state    <= DONE;
                            rd_valid <= 1'b1;
                            err      <= 1'b1;
                            d_rdata  <= 32'd0;
                        end else begin
                            state     <= BUSY;
                            timer     <= 8'd0;
                            mem_req   <= 1'b1;
                            mem_we    <= is_store;
                            mem_addr  <= {addr[31:2], 2'b00};
                            mem_wdata <= is_store ? st_wdata : 32'd0;
                            mem_wmask <= is_store ? st_mask : 4'b0000;
                        end
                    end
                end
                BUSY: begin
                    // An ack arriving on the final timeout cycle still completes normally.
                    if (mem_req && mem_ack) begin
                        state    <= DONE;
                        mem_req  <= 1'b0;
                        mem_we   <= 1'b0;
                        rd_valid <= 1'b1;
                        err      <= 1'b0;
                        d_rdata  <= op_load ? ld_data : 32'd0;
                    end else if (timeout_hit) begin
                        state    <= DONE;
                        mem_req  <= 1'b0;
                        mem_we   <= 1'b0;
                        rd_valid <= 1'b1;
                        err      <= 1'b1;
                        d_rdata  <= 32'd0;
                    end else begin
                        timer <= timer + 8'd1;
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    rd_valid <= 1'b0;
                    err      <= 1'b0;
                end
                default: begin
                    state    <= IDLE;
                    rd_valid <= 1'b0;
                    err      <= 1'b0;
                    mem_req  <= 1'b0;
                    mem_we   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// tb/tb_lsu_mem_ctrl.sv - self-checking bench for lsu_mem_ctrl against a behavioural access model
module tb_lsu_mem_ctrl;

    localparam int TB_TIMEOUT = 15;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        is_load = 1'b0;
    logic        is_store = 1'b0;
    logic [2:0]  funct3 = 3'd0;
    logic [31:0] addr = 32'd0;
    logic [31:0] st_data = 32'd0;
    logic        stall;
    logic [31:0] d_rdata;
    logic        rd_valid;
    logic        err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = 32'd0;

    int errors = 0;
    int checks = 0;

    lsu_mem_ctrl #(.TIMEOUT(TB_TIMEOUT)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .is_load(is_load), .is_store(is_store),
        .funct3(funct3), .addr(addr), .st_data(st_data), .stall(stall), .d_rdata(d_rdata),
        .rd_valid(rd_valid), .err(err), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        legal;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic [3:0]  mask;
        logic        we;
        logic        err;
        int          lat;
        int          req_cycles;
    } exp_t;

    typedef struct {
        int          lat;
        int          req_cycles;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic [3:0]  mask;
        logic        we;
        logic        err;
        logic        stall_acc;
        logic        stall_done;
        logic        stall_bad;
        logic        rv_after;
    } obs_t;

    function automatic exp_t model(input logic ld, input logic st, input logic [2:0] f3,
                                   input logic [31:0] a, input logic [31:0] sd,
                                   input logic [31:0] rd, input int ack_after);
        exp_t e;
        int size;
        int off;
        logic [31:0] v;
        logic [31:0] m;
        size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        e.legal = 1'b1;
        if (ld && st) e.legal = 1'b0;
        if (ld && (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7)) e.legal = 1'b0;
        if (st && f3 > 3'd2) e.legal = 1'b0;
`ifdef MISALIGN_TRAP_EN
        if ((int'(a[1:0]) % size) != 0) e.legal = 1'b0;
`endif
        off = (size == 4) ? 0 : (int'(a[1:0]) / size) * size;
        e.addr = a & 32'hFFFF_FFFC;
        e.we = st;
        m = ((32'd1 << size) - 32'd1) << off;
        e.mask = st ? m[3:0] : 4'b0000;
        if (size == 1)      e.wdata = (sd & 32'hFF) * 32'h0101_0101;
        else if (size == 2) e.wdata = (sd & 32'hFFFF) * 32'h0001_0001;
        else                e.wdata = sd;
        v = rd >> (8 * off);
        if (!e.legal) begin
            e.err = 1'b1; e.rdata = 32'd0; e.lat = 1; e.req_cycles = 0;
        end else if (ack_after >= TB_TIMEOUT) begin
            e.err = 1'b1; e.rdata = 32'd0; e.lat = TB_TIMEOUT + 1; e.req_cycles = TB_TIMEOUT;
        end else begin
            e.err = 1'b0; e.lat = ack_after + 2; e.req_cycles = ack_after + 1;
            case (f3)
                3'd0:    e.rdata = (v & 32'hFF) - (((v & 32'h80) != 0) ? 32'h100 : 32'h0);
                3'd1:    e.rdata = (v & 32'hFFFF) - (((v & 32'h8000) != 0) ? 32'h10000 : 32'h0);
                3'd4:    e.rdata = v & 32'hFF;
                3'd5:    e.rdata = v & 32'hFFFF;
                default: e.rdata = rd;
            endcase
            if (st) e.rdata = 32'd0;
        end
        return e;
    endfunction

    // Runs one access from IDLE; ack_after = number of wait cycles before ack (>= TIMEOUT means never).
    task automatic drive(input logic ld, input logic st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] sd, input logic [31:0] rd, input int ack_after,
                         output obs_t o);
        o = '{default: 0};
        o.lat = -1;
        req_valid = 1'b1; is_load = ld; is_store = st; funct3 = f3; addr = a; st_data = sd;
        #1 o.stall_acc = stall;
        @(posedge clk); #1;
        req_valid = 1'b0;
        is_load = 1'($urandom); is_store = 1'($urandom); funct3 = 3'($urandom);
        addr = $urandom; st_data = $urandom;
        for (int cyc = 1; cyc < 64; cyc++) begin
            if (rd_valid) begin
                o.lat = cyc; o.rdata = d_rdata; o.err = err; o.stall_done = stall;
                break;
            end
            if (mem_req) begin
                o.req_cycles++;
                o.addr = mem_addr; o.wdata = mem_wdata; o.mask = mem_wmask; o.we = mem_we;
                if (!stall) o.stall_bad = 1'b1;
                mem_ack = (o.req_cycles - 1 == ack_after);
                mem_rdata = mem_ack ? rd : $urandom;
            end else begin
                mem_ack = 1'($urandom);
                mem_rdata = $urandom;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        mem_ack = 1'b0;
        o.rv_after = rd_valid;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", stall); end
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req: got %b want 0", mem_req); end
        checks++; if (d_rdata !== 32'd0) begin errors++; $display("FAIL reset_d_rdata: got %h want 0", d_rdata); end
        checks++; if (rd_valid !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL reset_rd_valid_err: got %b%b want 00", rd_valid, err); end
        checks++; if ({mem_we, mem_wmask, mem_addr, mem_wdata} !== '0) begin errors++; $display("FAIL reset_bus: got we=%b mask=%b addr=%h wdata=%h want zeros", mem_we, mem_wmask, mem_addr, mem_wdata); end
    endtask

    task automatic test_store_byte();
        obs_t o;
        drive(1'b0, 1'b1, 3'b000, 32'h103, 32'hA5, 32'd0, 0, o);
        checks++; if (o.stall_acc !== 1'b1) begin errors++; $display("FAIL sb_stall_accept: got %b want 1", o.stall_acc); end
        checks++; if (o.addr !== 32'h100) begin errors++; $display("FAIL sb_addr: got %h want 00000100", o.addr); end
        checks++; if (o.mask !== 4'b1000) begin errors++; $display("FAIL sb_mask: got %b want 1000", o.mask); end
        checks++; if (o.wdata !== 32'hA5A5A5A5) begin errors++; $display("FAIL sb_wdata: got %h want a5a5a5a5", o.wdata); end
        checks++; if (o.we !== 1'b1) begin errors++; $display("FAIL sb_we: got %b want 1", o.we); end
        checks++; if (o.lat !== 2) begin errors++; $display("FAIL sb_latency: got %0d want 2", o.lat); end
        checks++; if (o.err !== 1'b0 || o.rdata !== 32'd0) begin errors++; $display("FAIL sb_result: got err=%b rdata=%h want 0/0", o.err, o.rdata); end
        checks++; if (o.rv_after !== 1'b0) begin errors++; $display("FAIL sb_rd_valid_pulse: got %b want 0", o.rv_after); end
    endtask

    task automatic test_load_byte();
        obs_t o;
        drive(1'b1, 1'b0, 3'b000, 32'h202, 32'd0, 32'h1280FF00, 3, o);
        checks++; if (o.rdata !== 32'hFFFFFF80) begin errors++; $display("FAIL lb_rdata: got %h want ffffff80", o.rdata); end
        checks++; if (o.lat !== 5) begin errors++; $display("FAIL lb_latency: got %0d want 5", o.lat); end
        checks++; if (o.stall_bad !== 1'b0 || o.stall_done !== 1'b0) begin errors++; $display("FAIL lb_stall: got busy_gap=%b done=%b want 0/0", o.stall_bad, o.stall_done); end
        checks++; if (o.mask !== 4'b0000 || o.we !== 1'b0) begin errors++; $display("FAIL lb_bus: got mask=%b we=%b want 0000/0", o.mask, o.we); end
        drive(1'b1, 1'b0, 3'b100, 32'h202, 32'd0, 32'h1280FF00, 3, o);
        checks++; if (o.rdata !== 32'h00000080) begin errors++; $display("FAIL lbu_rdata: got %h want 00000080", o.rdata); end
    endtask

    task automatic test_timeout();
        obs_t o;
        drive(1'b1, 1'b0, 3'b010, 32'h400, 32'd0, 32'h12345678, 1000, o);
        checks++; if (o.req_cycles !== TB_TIMEOUT) begin errors++; $display("FAIL to_req_cycles: got %0d want %0d", o.req_cycles, TB_TIMEOUT); end
        checks++; if (o.lat !== TB_TIMEOUT + 1) begin errors++; $display("FAIL to_latency: got %0d want %0d", o.lat, TB_TIMEOUT + 1); end
        checks++; if (o.err !== 1'b1 || o.rdata !== 32'd0) begin errors++; $display("FAIL to_result: got err=%b rdata=%h want 1/0", o.err, o.rdata); end
        mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checks++; if ({rd_valid, mem_req, stall} !== 3'b000) begin errors++; $display("FAIL to_late_ack: got rv/req/stall=%b want 000", {rd_valid, mem_req, stall}); end
        end
        mem_ack = 1'b0;
        drive(1'b1, 1'b0, 3'b010, 32'h404, 32'd0, 32'hCAFEF00D, TB_TIMEOUT - 1, o);
        checks++; if (o.err !== 1'b0 || o.rdata !== 32'hCAFEF00D) begin errors++; $display("FAIL ack_at_timeout: got err=%b rdata=%h want 0/cafef00d", o.err, o.rdata); end
    endtask

    task automatic test_misalign();
        obs_t o;
        drive(1'b1, 1'b0, 3'b001, 32'h301, 32'd0, 32'hBEEF8001, 0, o);
`ifdef MISALIGN_TRAP_EN
        checks++; if (o.req_cycles !== 0 || o.err !== 1'b1 || o.lat !== 1) begin errors++; $display("FAIL lh_misalign_trap: got req=%0d err=%b lat=%0d want 0/1/1", o.req_cycles, o.err, o.lat); end
`else
        checks++; if (o.addr !== 32'h300 || o.err !== 1'b0) begin errors++; $display("FAIL lh_misalign_addr: got addr=%h err=%b want 00000300/0", o.addr, o.err); end
        checks++; if (o.rdata !== 32'hFFFF8001) begin errors++; $display("FAIL lh_misalign_rdata: got %h want ffff8001", o.rdata); end
`endif
    endtask

    task automatic test_reset_mid_access();
        obs_t o;
        req_valid = 1'b1; is_load = 1'b1; is_store = 1'b0; funct3 = 3'b010; addr = 32'h700;
        @(posedge clk); #1 req_valid = 1'b0;
        @(posedge clk); #1;
        checks++; if (mem_req !== 1'b1 || stall !== 1'b1) begin errors++; $display("FAIL rst_busy: got req=%b stall=%b want 1/1", mem_req, stall); end
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        checks++; if ({mem_req, mem_we, stall, rd_valid, err} !== 5'b0) begin errors++; $display("FAIL rst_abandon: got req/we/stall/rv/err=%b want 00000", {mem_req, mem_we, stall, rd_valid, err}); end
        mem_ack = 1'b1;
        @(posedge clk); #1 mem_ack = 1'b0;
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL rst_late_ack: got %b want 0", rd_valid); end
        drive(1'b1, 1'b0, 3'b011, 32'h704, 32'd0, 32'h1, 0, o);
        checks++; if (o.req_cycles !== 0 || o.err !== 1'b1 || o.lat !== 1 || o.rdata !== 32'd0) begin errors++; $display("FAIL illegal_after_rst: got req=%0d err=%b lat=%0d rdata=%h want 0/1/1/0", o.req_cycles, o.err, o.lat, o.rdata); end
    endtask

    task automatic test_back_to_back();
        req_valid = 1'b1; is_load = 1'b0; is_store = 1'b1; funct3 = 3'b010; addr = 32'h500; st_data = 32'h11223344;
        @(posedge clk); #1 req_valid = 1'b0; mem_ack = 1'b1;
        @(posedge clk); #1 mem_ack = 1'b0;
        req_valid = 1'b1; is_load = 1'b1; is_store = 1'b0; funct3 = 3'b010; addr = 32'h600;
        #1;
        checks++; if (rd_valid !== 1'b1 || stall !== 1'b0) begin errors++; $display("FAIL b2b_done_ignores: got rv=%b stall=%b want 1/0", rd_valid, stall); end
        @(posedge clk); #1;
        checks++; if (rd_valid !== 1'b0 || stall !== 1'b1) begin errors++; $display("FAIL b2b_accept: got rv=%b stall=%b want 0/1", rd_valid, stall); end
        @(posedge clk); #1 req_valid = 1'b0;
        checks++; if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h600) begin errors++; $display("FAIL b2b_bus: got req=%b we=%b addr=%h want 1/0/00000600", mem_req, mem_we, mem_addr); end
        mem_ack = 1'b1; mem_rdata = 32'h55AA00FF;
        @(posedge clk); #1 mem_ack = 1'b0;
        checks++; if (rd_valid !== 1'b1 || d_rdata !== 32'h55AA00FF) begin errors++; $display("FAIL b2b_result: got rv=%b rdata=%h want 1/55aa00ff", rd_valid, d_rdata); end
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        obs_t o;
        exp_t e;
        logic ld, st;
        logic [2:0] f3;
        logic [31:0] a, sd, rd;
        int sel, wait_n;
        for (int n = 0; n < 60; n++) begin
            sel = int'($urandom_range(0, 7));
            ld = (sel == 0) || (sel >= 1 && sel <= 4);
            st = (sel == 0) || (sel >= 5);
            f3 = 3'($urandom);
            a = $urandom; sd = $urandom; rd = $urandom;
            wait_n = int'($urandom_range(0, TB_TIMEOUT + 2));
            e = model(ld, st, f3, a, sd, rd, wait_n);
            drive(ld, st, f3, a, sd, rd, wait_n, o);
            checks++; if (o.err !== e.err || o.rdata !== e.rdata) begin errors++; $display("FAIL rand%0d_result: got err=%b rdata=%h want %b/%h", n, o.err, o.rdata, e.err, e.rdata); end
            checks++; if (o.lat !== e.lat || o.req_cycles !== e.req_cycles) begin errors++; $display("FAIL rand%0d_timing: got lat=%0d req=%0d want %0d/%0d", n, o.lat, o.req_cycles, e.lat, e.req_cycles); end
            checks++; if (o.rv_after !== 1'b0 || o.stall_bad !== 1'b0) begin errors++; $display("FAIL rand%0d_pulse: got rv_after=%b stall_gap=%b want 0/0", n, o.rv_after, o.stall_bad); end
            if (e.legal) begin
                checks++; if (o.addr !== e.addr || o.we !== e.we || o.mask !== e.mask) begin errors++; $display("FAIL rand%0d_bus: got addr=%h we=%b mask=%b want %h/%b/%b", n, o.addr, o.we, o.mask, e.addr, e.we, e.mask); end
                if (st) begin
                    checks++; if (o.wdata !== e.wdata) begin errors++; $display("FAIL rand%0d_wdata: got %h want %h", n, o.wdata, e.wdata); end
                end
            end
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_store_byte();
        test_load_byte();
        test_timeout();
        test_misalign();
        test_reset_mid_access();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
